// File: rtl/mnist_result_counter_pkg.sv
// rtl/mnist_result_counter_pkg.sv - shared constants, result type and label decode
package mnist_result_counter_pkg;
   localparam int CLASS_NUM_DEF      = 10;
   localparam int USER_WIDTH_DEF     = 8;
   localparam int COUNT_WIDTH_DEF    = 14;
   localparam int FRAME_ID_WIDTH_DEF = 16;
   localparam int ONEHOT_MAX         = 256;

   typedef struct packed {
      logic [COUNT_WIDTH_DEF-1:0]    match_cnt;
      logic [COUNT_WIDTH_DEF-1:0]    hit_cnt;
      logic [COUNT_WIDTH_DEF-1:0]    err_cnt;
      logic [FRAME_ID_WIDTH_DEF-1:0] frame_id;
   } result_t;

   // Labels beyond the decode range give all-zero, which matches no class vector.
   function automatic logic [ONEHOT_MAX-1:0] label_to_onehot(input logic [31:0] label);
      logic [ONEHOT_MAX-1:0] v;
      v = '0;
      if (label < ONEHOT_MAX) v[label[$clog2(ONEHOT_MAX)-1:0]] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/mnist_result_compare.sv
// rtl/mnist_result_compare.sv - stage-1 registered label compare and frame position tracking
module mnist_result_compare
   import mnist_result_counter_pkg::*;
#(
   parameter int USER_WIDTH  = USER_WIDTH_DEF,
   parameter int CLASS_NUM   = CLASS_NUM_DEF,
   parameter int FRAME_SIZE  = 10000,
   parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cke_i,
   input  logic                  clear_i,
   input  logic [USER_WIDTH-1:0] s_user_i,
   input  logic [CLASS_NUM-1:0]  s_data_i,
   input  logic                  s_valid_i,
   output logic                  match_o,
   output logic                  hit_o,
   output logic                  err_o,
   output logic                  last_o
);
   localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(FRAME_SIZE - 1);

   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic match_q, match_d, hit_q, hit_d, err_q, err_d, last_q, last_d;
   logic [ONEHOT_MAX-1:0] exp_onehot_w, data_ext_w;
   logic label_ok_w;

   assign exp_onehot_w = label_to_onehot(32'(s_user_i));
   assign data_ext_w   = ONEHOT_MAX'(s_data_i);
   assign label_ok_w   = 32'(s_user_i) < 32'(CLASS_NUM);

   always_comb begin
      cnt_d   = cnt_q;
      match_d = match_q;
      hit_d   = hit_q;
      err_d   = err_q;
      last_d  = last_q;
      if (cke_i) begin
         if (clear_i) begin
            cnt_d   = '0;
            match_d = 1'b0;
            hit_d   = 1'b0;
            err_d   = 1'b0;
            last_d  = 1'b0;
         end else begin
            match_d = s_valid_i && label_ok_w && (data_ext_w == exp_onehot_w);
            hit_d   = s_valid_i && label_ok_w && |(data_ext_w & exp_onehot_w);
            err_d   = s_valid_i && !label_ok_w;
            last_d  = s_valid_i && (cnt_q == LAST_IDX);
            if (s_valid_i) cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + COUNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         match_q <= 1'b0;
         hit_q   <= 1'b0;
         err_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         match_q <= match_d;
         hit_q   <= hit_d;
         err_q   <= err_d;
         last_q  <= last_d;
      end
   end

   assign match_o = match_q;
   assign hit_o   = hit_q;
   assign err_o   = err_q;
   assign last_o  = last_q;
endmodule

// File: rtl/mnist_result_counter.sv
// rtl/mnist_result_counter.sv - frame accumulator and result handshake for the MNIST classifier stream
module mnist_result_counter
   import mnist_result_counter_pkg::*;
#(
   parameter int USER_WIDTH     = USER_WIDTH_DEF,
   parameter int CLASS_NUM      = CLASS_NUM_DEF,
   parameter int FRAME_SIZE     = 10000,
   parameter int COUNT_WIDTH    = COUNT_WIDTH_DEF,
   parameter int FRAME_ID_WIDTH = FRAME_ID_WIDTH_DEF
) (
   input  logic                      reset_n,
   input  logic                      clk,
   input  logic                      cke,
   input  logic                      clear,
   input  logic [USER_WIDTH-1:0]     s_user,
   input  logic [CLASS_NUM-1:0]      s_data,
   input  logic                      s_valid,
   output logic [COUNT_WIDTH-1:0]    m_match_count,
   output logic [COUNT_WIDTH-1:0]    m_hit_count,
   output logic [COUNT_WIDTH-1:0]    m_error_count,
   output logic [FRAME_ID_WIDTH-1:0] m_frame_id,
   output logic                      m_overrun,
   output logic                      m_valid,
   input  logic                      m_ready
);
   typedef struct packed {
      logic [COUNT_WIDTH-1:0]    match_cnt;
      logic [COUNT_WIDTH-1:0]    hit_cnt;
      logic [COUNT_WIDTH-1:0]    err_cnt;
      logic [FRAME_ID_WIDTH-1:0] frame_id;
   } frame_res_t;

   logic match_w, hit_w, err_w, last_w;
   frame_res_t acc_q, acc_d, sum_w, res_q, res_d, out_q, out_d;
   logic res_vld_q, res_vld_d, valid_q, valid_d, overrun_q, overrun_d;

   mnist_result_compare #(
      .USER_WIDTH (USER_WIDTH),
      .CLASS_NUM  (CLASS_NUM),
      .FRAME_SIZE (FRAME_SIZE),
      .COUNT_WIDTH(COUNT_WIDTH)
   ) u_compare (
      .clk      (clk),
      .reset_n  (reset_n),
      .cke_i    (cke),
      .clear_i  (clear),
      .s_user_i (s_user),
      .s_data_i (s_data),
      .s_valid_i(s_valid),
      .match_o  (match_w),
      .hit_o    (hit_w),
      .err_o    (err_w),
      .last_o   (last_w)
   );

   // acc_q.frame_id is the index of the frame currently being accumulated
   always_comb begin
      sum_w           = acc_q;
      sum_w.match_cnt = acc_q.match_cnt + COUNT_WIDTH'(match_w);
      sum_w.hit_cnt   = acc_q.hit_cnt + COUNT_WIDTH'(hit_w);
      sum_w.err_cnt   = acc_q.err_cnt + COUNT_WIDTH'(err_w);
   end

   always_comb begin
      acc_d     = acc_q;
      res_d     = res_q;
      res_vld_d = res_vld_q;
      out_d     = out_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (valid_q && m_ready) valid_d = 1'b0;
      if (cke) begin
         // A completed frame already in the result stage is delivered even during clear.
         if (res_vld_q) begin
            out_d   = res_q;
            valid_d = 1'b1;
            if (valid_q && !m_ready) overrun_d = 1'b1;
         end
         res_vld_d = 1'b0;
         if (clear) begin
            acc_d     = '0;
            overrun_d = 1'b0;
         end else if (last_w) begin
            res_d           = sum_w;
            res_vld_d       = 1'b1;
            acc_d           = '0;
            acc_d.frame_id  = acc_q.frame_id + FRAME_ID_WIDTH'(1);
         end else begin
            acc_d = sum_w;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q     <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
         out_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
         out_q     <= out_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign m_match_count = out_q.match_cnt;
   assign m_hit_count   = out_q.hit_cnt;
   assign m_error_count = out_q.err_cnt;
   assign m_frame_id    = out_q.frame_id;
   assign m_overrun     = overrun_q;
   assign m_valid       = valid_q;
endmodule

// File: tb/tb_mnist_result_counter.sv
// tb/tb_mnist_result_counter.sv - randomized bench with reference model for mnist_result_counter
module tb_mnist_result_counter;
   import mnist_result_counter_pkg::*;

   logic clk = 1'b0;
   logic reset_n, cke, clear, s_valid, m_ready;
   logic [7:0]  s_user;
   logic [9:0]  s_data;
   logic [13:0] mc [2];
   logic [13:0] hc [2];
   logic [13:0] ec [2];
   logic [15:0] fid [2];
   logic        ov [2];
   logic        vl [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mnist_result_counter #(.USER_WIDTH(8), .CLASS_NUM(10), .FRAME_SIZE(4),
                          .COUNT_WIDTH(14), .FRAME_ID_WIDTH(16)) dut4 (
      .reset_n(reset_n), .clk(clk), .cke(cke), .clear(clear),
      .s_user(s_user), .s_data(s_data), .s_valid(s_valid),
      .m_match_count(mc[0]), .m_hit_count(hc[0]), .m_error_count(ec[0]),
      .m_frame_id(fid[0]), .m_overrun(ov[0]), .m_valid(vl[0]), .m_ready(m_ready));

   mnist_result_counter #(.USER_WIDTH(8), .CLASS_NUM(10), .FRAME_SIZE(1),
                          .COUNT_WIDTH(14), .FRAME_ID_WIDTH(16)) dut1 (
      .reset_n(reset_n), .clk(clk), .cke(cke), .clear(clear),
      .s_user(s_user), .s_data(s_data), .s_valid(s_valid),
      .m_match_count(mc[1]), .m_hit_count(hc[1]), .m_error_count(ec[1]),
      .m_frame_id(fid[1]), .m_overrun(ov[1]), .m_valid(vl[1]), .m_ready(m_ready));

   // Reference model: running frame totals plus completed results waiting out their latency.
   int      fsz [2] = '{4, 1};
   int      cnt [2], am [2], ah [2], ae [2], fidx [2];
   result_t out_m [2];
   bit      ov_m [2], vl_m [2];
   result_t pres [2][2];
   int      pdly [2][2];
   bit      pv [2][2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         cnt[i] = 0; am[i] = 0; ah[i] = 0; ae[i] = 0; fidx[i] = 0;
         out_m[i] = '0; ov_m[i] = 1'b0; vl_m[i] = 1'b0;
         for (int k = 0; k < 2; k++) pv[i][k] = 1'b0;
      end
   endtask

   task automatic model_edge(input int i);
      bit stalled, placed;
      int lab;
      stalled = vl_m[i] && !m_ready;
      if (vl_m[i] && m_ready) vl_m[i] = 1'b0;
      if (!cke) return;
      for (int k = 0; k < 2; k++) begin
         if (pv[i][k]) begin
            pdly[i][k]--;
            if (pdly[i][k] == 0) begin
               out_m[i] = pres[i][k];
               vl_m[i]  = 1'b1;
               if (stalled) ov_m[i] = 1'b1;
               pv[i][k] = 1'b0;
            end
         end
      end
      if (clear) begin
         for (int k = 0; k < 2; k++) pv[i][k] = 1'b0;
         cnt[i] = 0; am[i] = 0; ah[i] = 0; ae[i] = 0; fidx[i] = 0;
         ov_m[i] = 1'b0;
         return;
      end
      if (!s_valid) return;
      lab = int'(s_user);
      if (lab >= 10) ae[i]++;
      else begin
         if (int'(s_data) == (1 << lab)) am[i]++;
         if (s_data[lab]) ah[i]++;
      end
      cnt[i]++;
      if (cnt[i] == fsz[i]) begin
         placed = 1'b0;
         for (int k = 0; k < 2; k++) begin
            if (!pv[i][k] && !placed) begin
               pres[i][k] = '{14'(am[i]), 14'(ah[i]), 14'(ae[i]), 16'(fidx[i])};
               pdly[i][k] = 2;
               pv[i][k]   = 1'b1;
               placed     = 1'b1;
            end
         end
         fidx[i]++;
         cnt[i] = 0; am[i] = 0; ah[i] = 0; ae[i] = 0;
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("valid%0d", i), 64'(vl[i]), 64'(vl_m[i]));
         chk($sformatf("overrun%0d", i), 64'(ov[i]), 64'(ov_m[i]));
         chk($sformatf("result%0d", i), 64'({mc[i], hc[i], ec[i], fid[i]}), 64'(out_m[i]));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic send(input int lab, input int data);
      s_valid = 1'b1;
      s_user  = 8'(lab);
      s_data  = 10'(data);
      cycle();
      s_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic chk_res(input string tag, input int i, input int m, input int h, input int e, input int f);
      chk(tag, 64'({mc[i], hc[i], ec[i], fid[i]}), 64'({14'(m), 14'(h), 14'(e), 16'(f)}));
   endtask

   task automatic frame_a();
      send(3, 'h008); send(7, 'h080); send(1, 'h003); send(0, 'h001);
   endtask

   initial begin
      reset_n = 1'b0; cke = 1'b1; clear = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      s_user = '0; s_data = '0;
      do_reset();

      // basic frame and two-edge latency
      frame_a();
      chk("t1_lat0", 64'(vl[0]), 64'd0);
      idle(1);
      chk("t1_lat1", 64'(vl[0]), 64'd0);
      idle(1);
      chk("t1_valid", 64'(vl[0]), 64'd1);
      chk_res("t1_res", 0, 3, 4, 0, 0);

      // out-of-range label on a single-sample frame
      do_reset();
      send(12, 'h000);
      idle(2);
      chk("t2_valid", 64'(vl[1]), 64'd1);
      chk_res("t2_res", 1, 0, 0, 1, 0);

      // two frames with no acceptance -> overrun, then drain
      do_reset();
      frame_a(); frame_a();
      idle(2);
      chk("t3_valid", 64'(vl[0]), 64'd1);
      chk("t3_ovr", 64'(ov[0]), 64'd1);
      chk_res("t3_res", 0, 3, 4, 0, 1);
      m_ready = 1'b1;
      idle(1);
      chk("t3_drop", 64'(vl[0]), 64'd0);
      chk("t3_sticky", 64'(ov[0]), 64'd1);
      m_ready = 1'b0;

      // new result lands on the handshake edge
      do_reset();
      frame_a();
      send(2, 'h004); send(2, 'h006); send(5, 'h000); send(11, 'h3ff);
      idle(1);
      m_ready = 1'b1;
      idle(1);
      chk("t4_valid", 64'(vl[0]), 64'd1);
      chk("t4_ovr", 64'(ov[0]), 64'd0);
      chk_res("t4_res", 0, 1, 2, 1, 1);

      // clock enable freeze mid-frame
      do_reset();
      m_ready = 1'b1;
      send(3, 'h008); send(7, 'h080);
      cke = 1'b0; s_valid = 1'b1; s_user = 8'd1; s_data = 10'h002;
      idle(5);
      chk("t5_frozen", 64'(vl[0]), 64'd0);
      cke = 1'b1; s_valid = 1'b0;
      send(1, 'h002); send(4, 'h010);
      idle(2);
      chk("t5_valid", 64'(vl[0]), 64'd1);
      chk_res("t5_res", 0, 4, 4, 0, 0);
      m_ready = 1'b0;

      // async reset mid-frame, then clear with a sample in flight
      do_reset();
      send(3, 'h008); send(7, 'h080);
      do_reset();
      send(9, 'h200);
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      frame_a();
      idle(2);
      chk("t6_valid", 64'(vl[0]), 64'd1);
      chk_res("t6_res", 0, 3, 4, 0, 0);

      // randomized traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int lab;
         lab     = int'($urandom_range(0, 12));
         cke     = ($urandom % 100) < 85;
         clear   = ($urandom % 100) < 2;
         s_valid = ($urandom % 100) < 70;
         m_ready = ($urandom % 100) < 60;
         s_user  = 8'(lab);
         case ($urandom_range(0, 3))
            0:       s_data = 10'(1 << lab);
            1:       s_data = 10'(1 << lab) | 10'(1 << $urandom_range(0, 9));
            2:       s_data = 10'($urandom);
            default: s_data = '0;
         endcase
         cycle();
         if (($urandom % 500) == 0) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
